spi_regfile_periph: RTL

Parametrised SPI (mode 0) peripheral exposing a bank of `NUM_REGS` read/write registers of `DATA_W` bits each. It is the successor of the fixed 9×8-bit PWM control interface: it adds true read and write commands, per-word commit with write strobes, access-error reporting and optional burst auto-increment. It sits between the chip's SPI pins and the PWM/config fabric, entirely in the `clk` domain.

---
 rtl/spi_regfile_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 45 ++++
 rtl/spi_regfile_periph.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and frame constants for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DRAIN
  } spi_state_e;

  localparam int SPI_ADDR_W   = 7;
  localparam int SPI_HDR_BITS = 8;
  // W is the first bit on the wire, so it lands in the MSB of the shifted-in header byte
  localparam int SPI_W_BIT    = SPI_HDR_BITS - 1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with registered level and
// one-cycle rise/fall pulses all aligned SYNC_STAGES+1 clocks after the pin edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    lvl_d  = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~lvl_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & lvl_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      lvl_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 register-file peripheral: header (W + 7-bit address) then DATA_W-bit words.
// Build option: define SPI_BURST_EN for multi-word frames with address auto-increment.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nCS high, waiting for frame start
// ST_HDR   | shifting in W bit and 7-bit address
// ST_DATA  | shifting data words in (write) / out (read)
// ST_DRAIN | frame finished or invalidated; ignore SCLK until nCS rises
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 9,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic                       err
);

  localparam int CNT_W = 6;

  logic ncs_lvl, ncs_rise, ncs_fall_unused;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(nCS),
    .lvl(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(SCLK),
    .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(COPI),
    .lvl(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  spi_state_e             state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]      rx_q, rx_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic [SPI_ADDR_W-1:0]  addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic                   cipo_q, cipo_d;
  logic                   cipo_oe_q, cipo_oe_d;
  logic [NUM_REGS-1:0]    wr_stb_q, wr_stb_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];

  logic [DATA_W-1:0]       word;
  logic [SPI_HDR_BITS-1:0] hdr;
  logic [DATA_W-1:0]       ld;
  logic                    ld_en;

  function automatic logic addr_ok(input logic [SPI_ADDR_W-1:0] a);
    return ({1'b0, a} < 8'(NUM_REGS));
  endfunction

  function automatic logic [DATA_W-1:0] rd_word(input logic [SPI_ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (a == SPI_ADDR_W'(k)) r = regs_q[k];
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    cipo_d    = cipo_q;
    cipo_oe_d = ~ncs_lvl;
    wr_stb_d  = '0;
    err_d     = 1'b0;
    regs_d    = regs_q;
    ld        = '0;
    ld_en     = 1'b0;
    word      = {rx_q, copi_lvl};
    hdr       = word[SPI_HDR_BITS-1:0];

    case (state_q)
      ST_IDLE: begin
        cipo_d    = 1'b0;
        bit_cnt_d = '0;
        if (!ncs_lvl) state_d = ST_HDR;
      end

      ST_HDR: begin
        if (sclk_rise) begin
          rx_d = word[DATA_W-2:0];
          if (bit_cnt_q == CNT_W'(SPI_HDR_BITS - 1)) begin
            wr_d      = hdr[SPI_W_BIT];
            addr_d    = hdr[SPI_ADDR_W-1:0];
            bit_cnt_d = '0;
            state_d   = ST_DATA;
            ld_en     = 1'b1;
            ld        = hdr[SPI_W_BIT] ? '0 : rd_word(hdr[SPI_ADDR_W-1:0]);
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (sclk_rise) begin
          rx_d = word[DATA_W-2:0];
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (!addr_ok(addr_q)) begin
              err_d = 1'b1;
            end else if (wr_q) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (addr_q == SPI_ADDR_W'(k)) begin
                  regs_d[k]   = word;
                  wr_stb_d[k] = 1'b1;
                end
              end
            end
`ifdef SPI_BURST_EN
            addr_d = addr_q + 1'b1;
            ld_en  = 1'b1;
            ld     = wr_q ? '0 : rd_word(addr_q + 1'b1);
`else
            state_d = ST_DRAIN;
            cipo_d  = 1'b0;
            tx_d    = '0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall && bit_cnt_q != '0) begin
          // The first bit of a word is presented at load time, so the falling
          // edge right after a word boundary must not advance the shifter.
          cipo_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
      end

      ST_DRAIN: begin
        cipo_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase

    if (ld_en) begin
      cipo_d = ld[DATA_W-1];
      tx_d   = {ld[DATA_W-2:0], 1'b0};
    end

    // A word completing on the same cycle still commits above; only then close the frame.
    if (ncs_rise) begin
      state_d = ST_IDLE;
      cipo_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // A frame cut by reset must not be decoded from its middle.
      state_q   <= nCS ? ST_IDLE : ST_DRAIN;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
      wr_stb_q  <= '0;
      err_q     <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      cipo_q    <= cipo_d;
      cipo_oe_q <= cipo_oe_d;
      wr_stb_q  <= wr_stb_d;
      err_q     <= err_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    regs = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

  assign CIPO    = cipo_q;
  assign CIPO_oe = cipo_oe_q;
  assign wr_stb  = wr_stb_q;
  assign err     = err_q;

endmodule
